uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_sync.sv | 14 +
 rtl/uart_rx.sv | 79 +++++++
 tb/tb_uart_rx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: frame levels, defaults and receiver state encoding shared across the UART
package uart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] STOP = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for an asynchronous input with selectable reset level
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) {q, m} <= {RST_VAL, RST_VAL};
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver with valid/read output register, frame-error and overrun pulses
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 en,
  input  logic                 rxd,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dvalid,
  output logic                 ferr,
  output logic                 ovr
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);
  logic                 rxd_s;
  logic [2:0]           state;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bits;
  logic [DATA_BITS-1:0] sr;
  logic                 stop_smp, good, bad;
  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_(rst_), .d(rxd), .q(rxd_s));
  assign stop_smp = en && state == STOP && tick == T_END;
  assign good = stop_smp && rxd_s == STOP_LVL;
  assign bad = stop_smp && rxd_s != STOP_LVL;
  // the IDLE tick that sees the start edge counts as tick 0, so START compares one below the mid index
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      state <= IDLE;
      tick <= '0;
      bits <= '0;
      sr <= '0;
    end else if (en) begin
      case (state)
        IDLE: if (rxd_s == START_LVL) begin
          state <= START;
          tick <= '0;
        end
        START: if (tick == T_MID) begin
          state <= rxd_s == START_LVL ? DATA : IDLE;
          tick <= '0;
          bits <= '0;
        end else tick <= tick + 1'b1;
        DATA: if (tick == T_END) begin
          tick <= '0;
          sr <= {rxd_s, sr[DATA_BITS-1:1]};
          bits <= bits + 1'b1;
          if (bits == B_END) state <= STOP;
        end else tick <= tick + 1'b1;
        STOP: if (tick == T_END) begin
          tick <= '0;
          state <= rxd_s == STOP_LVL ? IDLE : WAIT_IDLE;
        end else tick <= tick + 1'b1;
        WAIT_IDLE: if (rxd_s == STOP_LVL) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      dout <= '0;
      dvalid <= 1'b0;
      ferr <= 1'b0;
      ovr <= 1'b0;
    end else begin
      ferr <= bad;
      ovr <= good && dvalid && !rd;
      if (good && (!dvalid || rd)) begin
        dout <= sr;
        dvalid <= 1'b1;
      end else if (rd && dvalid) dvalid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed 8N1 frames against hand-computed bytes, flags and latency
module tb_uart_rx;
  logic clk = 1'b0, rst_ = 1'b0, en = 1'b1, rxd = 1'b1, rd = 1'b0;
  logic [7:0] dout;
  logic dvalid, ferr, ovr;
  int checks = 0, failures = 0;
  int en_div = 1, ecnt = 0;
  int nferr = 0, novr = 0, nrise = 0, b_ferr, b_ovr, b_rise;
  logic dv_q = 1'b0;
  uart_rx dut (.clk(clk), .rst_(rst_), .en(en), .rxd(rxd), .rd(rd), .dout(dout), .dvalid(dvalid), .ferr(ferr), .ovr(ovr));
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    en = ecnt == 0;
    ecnt = (ecnt + 1) % en_div;
  end
  always @(negedge clk) begin
    if (ferr) nferr++;
    if (ovr) novr++;
    if (dvalid && !dv_q) nrise++;
    dv_q = dvalid;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input int cpb);
    rxd = 1'b0;
    cyc(cpb);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      cyc(cpb);
    end
    rxd = stop;
    cyc(cpb);
    rxd = 1'b1;
  endtask
  task automatic read;
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
  endtask
  task automatic snap;
    b_ferr = nferr;
    b_ovr = novr;
    b_rise = nrise;
  endtask
  initial begin
    cyc(3);
    chk("rst_dout", dout, 0);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    rst_ = 1'b1;
    cyc(5);
    snap();
    fork
      send(8'hA5, 1'b1, 16);
      begin
        cyc(153);
        chk("lat_pre", dvalid, 0);
        cyc(1);
        chk("lat_rise", dvalid, 1);
      end
    join
    cyc(4);
    chk("a5_dout", dout, 8'hA5);
    chk("a5_rise", nrise - b_rise, 1);
    chk("a5_ferr", nferr - b_ferr, 0);
    chk("a5_ovr", novr - b_ovr, 0);
    cyc(20);
    chk("a5_held", dvalid, 1);
    read();
    chk("rd_clear", dvalid, 0);
    send(8'h3C, 1'b1, 16);
    cyc(4);
    chk("3c_dout", dout, 8'h3C);
    chk("3c_dvalid", dvalid, 1);
    read();
    snap();
    rxd = 1'b0;
    cyc(4);
    rxd = 1'b1;
    cyc(40);
    chk("glitch_dvalid", dvalid, 0);
    chk("glitch_rise", nrise - b_rise, 0);
    chk("glitch_ferr", nferr - b_ferr, 0);
    send(8'h81, 1'b1, 16);
    cyc(4);
    chk("81_dout", dout, 8'h81);
    chk("81_dvalid", dvalid, 1);
    read();
    snap();
    send(8'h55, 1'b0, 16);
    rxd = 1'b0;
    cyc(40);
    chk("ferr_cnt", nferr - b_ferr, 1);
    chk("ferr_dvalid", dvalid, 0);
    chk("ferr_wait", dut.state, 4);
    rxd = 1'b1;
    cyc(10);
    chk("ferr_idle", dut.state, 0);
    send(8'h0F, 1'b1, 16);
    cyc(4);
    chk("0f_dout", dout, 8'h0F);
    chk("0f_ferr", nferr - b_ferr, 1);
    read();
    snap();
    send(8'h11, 1'b1, 16);
    send(8'h22, 1'b1, 16);
    cyc(4);
    chk("ovr_dout", dout, 8'h11);
    chk("ovr_dvalid", dvalid, 1);
    chk("ovr_cnt", novr - b_ovr, 1);
    read();
    chk("ovr_clear", dvalid, 0);
    send(8'h11, 1'b1, 16);
    cyc(4);
    snap();
    fork
      send(8'h22, 1'b1, 16);
      begin
        cyc(153);
        read();
      end
    join
    cyc(4);
    chk("rdsim_dout", dout, 8'h22);
    chk("rdsim_dvalid", dvalid, 1);
    chk("rdsim_ovr", novr - b_ovr, 0);
    snap();
    fork
      send(8'hF0, 1'b1, 16);
      begin
        cyc(88);
        rst_ = 1'b0;
        cyc(3);
        chk("mrst_dout", dout, 0);
        chk("mrst_dvalid", dvalid, 0);
        chk("mrst_ferr", ferr, 0);
        chk("mrst_ovr", ovr, 0);
        rst_ = 1'b1;
      end
    join
    cyc(20);
    chk("mrst_after", dvalid, 0);
    chk("mrst_flags", (nferr - b_ferr) + (novr - b_ovr), 0);
    en_div = 3;
    cyc(6);
    send(8'hC3, 1'b1, 48);
    cyc(10);
    chk("en3_dout", dout, 8'hC3);
    chk("en3_dvalid", dvalid, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
